storage_arbiter: RTL and testbench
==================================

Name: storage_arbiter

Overview:
- Parametrised, sequential successor to the combinational enable-based storage multiplexer in the matrix calculator.
- Arbitrates N_CLIENTS independent masters onto one single-port synchronous matrix storage: input, display, calculator, and future clients.
- Uses a per-cycle valid/grant handshake, round-robin or fixed priority, optional burst lock, and a tagged read-return pipeline.
- Read data is routed back to the issuing client only.

Parameters:
N_CLIENTS, 4, number of requesting masters (2..8)
ADDR_W, 8, storage address width
DATA_W, 32, storage data width
RD_LATENCY, 1, cycles from o_mem_addr valid to i_mem_rdata valid (1..4)
PRIO_MODE, 0, 0 = round-robin; 1 = fixed priority, lowest index wins

Ports:
clk  in  1  system clock
sys_rst  in  1  asynchronous, active-high reset
i_req  in  N_CLIENTS  per-client access request
i_we  in  N_CLIENTS  per-client write enable (1 = write, 0 = read)
i_lock  in  N_CLIENTS  per-client burst lock
i_addr  in  N_CLIENTS*ADDR_W  packed addresses, client k at [k*ADDR_W +: ADDR_W]
i_wdata  in  N_CLIENTS*DATA_W  packed write data, same packing
o_gnt  out  N_CLIENTS  one-hot grant, combinational, same cycle as request
o_rvalid  out  N_CLIENTS  one-hot read-return strobe
o_rdata  out  DATA_W  read-return data, shared by all clients
o_mem_we  out  1  storage write enable (registered)
o_mem_addr  out  ADDR_W  storage address (registered)
o_mem_wdata  out  DATA_W  storage write data (registered)
i_mem_rdata  in  DATA_W  storage read data
o_busy  out  1  high while any read is in flight or a lock is held

Behaviour:
- Clock and reset: one clock, clk. sys_rst is asynchronous and active-high.
- Reset values:
  - o_mem_we = 0, o_mem_addr = 0, o_mem_wdata = 0.
  - o_rvalid = 0, o_rdata = 0, o_busy = 0.
  - Round-robin pointer = N_CLIENTS-1, so client 0 wins first.
  - Lock owner cleared; read-tag pipeline cleared.
- Transfer: occurs on a clock edge where i_req[k] && o_gnt[k].
  - At most one grant per cycle.
  - o_gnt is 0 while no request is present.
  - A client holds i_req, i_we, i_addr and i_wdata stable until granted.
- Arbitration, no lock held:
  - PRIO_MODE=0: search starts at (ptr+1) mod N_CLIENTS, wrapping. On a transfer, ptr <= granted index. The pointer is unchanged on idle cycles.
  - PRIO_MODE=1: the lowest requesting index wins. The pointer is unused.
- Lock:
  - A transfer with i_lock[k]=1 makes k the lock owner.
  - While an owner exists, o_gnt may go only to the owner. Other requests stall.
  - The lock is released on the first edge where the owner has i_req=0 or i_lock=0.
  - Arbitration resumes in the same cycle the lock is released; the ptr rule still applies.
- Memory drive:
  - On a transfer, o_mem_we/o_mem_addr/o_mem_wdata load the winner's values at that edge.
  - Without a transfer, o_mem_we <= 0. Address and data hold their last values.
  - Latency is 1 cycle from grant to the storage port.
- Read return:
  - A read transfer pushes tag {valid, client index} into a RD_LATENCY-deep shift register, aligned with o_mem_addr.
  - RD_LATENCY cycles after o_mem_addr is presented, o_rvalid[tag] = 1 for exactly 1 cycle and o_rdata = i_mem_rdata, registered.
  - Total request-to-rvalid = RD_LATENCY+1 cycles.
  - Writes push an invalid tag.
  - Back-to-back reads from any clients are fully pipelined at 1 per cycle, and returns are in issue order.
- o_busy: OR of valid tags in the pipeline OR lock owner present.
- Simultaneous events:
  - All clients requesting: round-robin serves each exactly once per N_CLIENTS grants.
  - A read and a write to the same address in consecutive cycles follow storage order; the arbiter adds no forwarding.
- Reset mid-operation: in-flight tags are discarded, no o_rvalid is emitted, and the lock drops.
- An unused high i_lock without i_req has no effect.

Test Plan:
- Single read: client 2 reads addr 0x10, storage holds 0x0000_00AB, RD_LATENCY=1 -> o_gnt=0100 in cycle 0; o_mem_addr=0x10 in cycle 1; o_rvalid=0100 and o_rdata=0xAB in cycle 2.
- Round-robin fairness: all 4 clients request continuously for 8 cycles, PRIO_MODE=0 -> grant sequence 0,1,2,3,0,1,2,3. With PRIO_MODE=1 -> client 0 is granted on all 8 cycles.
- Lock burst: client 1 writes 3 words with i_lock=1 while client 0 requests -> client 0 stalls 3 cycles and is granted in the cycle after client 1 drops i_lock.
- Pipelined reads, RD_LATENCY=3: clients 0,3,1 read on consecutive cycles -> o_rvalid pulses 0001, 1000, 0010 on cycles 4,5,6, each with correct data.
- Reset mid-flight: sys_rst asserted one cycle after a read grant -> no o_rvalid ever appears; o_busy=0; the next grant goes to client 0.
- Write then read-back: client 0 writes 0xDEADBEEF to 0x20, then client 1 reads 0x20 -> client 1 receives 0xDEADBEEF; o_rvalid never pulses for the write.

Source files
------------

// File: rtl/storage_arbiter.sv
// Arbitrates N_CLIENTS masters onto one single-port synchronous storage with
// round-robin or fixed priority, burst lock and a tagged read-return pipeline.
module storage_arbiter #(
    parameter int N_CLIENTS  = 4,
    parameter int ADDR_W     = 8,
    parameter int DATA_W     = 32,
    parameter int RD_LATENCY = 1,
    parameter int PRIO_MODE  = 0
) (
    input  logic                          clk,
    input  logic                          sys_rst,
    input  logic [N_CLIENTS-1:0]          i_req,
    input  logic [N_CLIENTS-1:0]          i_we,
    input  logic [N_CLIENTS-1:0]          i_lock,
    input  logic [N_CLIENTS*ADDR_W-1:0]   i_addr,
    input  logic [N_CLIENTS*DATA_W-1:0]   i_wdata,
    output logic [N_CLIENTS-1:0]          o_gnt,
    output logic [N_CLIENTS-1:0]          o_rvalid,
    output logic [DATA_W-1:0]             o_rdata,
    output logic                          o_mem_we,
    output logic [ADDR_W-1:0]             o_mem_addr,
    output logic [DATA_W-1:0]             o_mem_wdata,
    input  logic [DATA_W-1:0]             i_mem_rdata,
    output logic                          o_busy
);

    localparam int IDX_W = $clog2(N_CLIENTS);

    logic [IDX_W-1:0]      rr_ptr;
    logic [IDX_W-1:0]      lock_idx;
    logic                  lock_valid;
    logic                  lock_hold;
    logic [IDX_W-1:0]      win_idx;
    logic                  win_found;
    int                    cand;
    logic [RD_LATENCY-1:0] tag_valid;
    logic [IDX_W-1:0]      tag_idx [RD_LATENCY];

    // The owner keeps the port only while it still requests with lock; the
    // moment it lets go, normal arbitration takes over in that same cycle.
    // Loops run backwards so the last hit is the highest-priority candidate.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = 0;
        o_gnt     = '0;
        lock_hold = lock_valid && i_req[lock_idx] && i_lock[lock_idx];
        if (lock_hold) begin
            win_found = 1'b1;
            win_idx   = lock_idx;
        end else if (PRIO_MODE == 1) begin
            for (int i = N_CLIENTS - 1; i >= 0; i--) begin
                if (i_req[i]) begin
                    win_found = 1'b1;
                    win_idx   = IDX_W'(i);
                end
            end
        end else begin
            for (int i = N_CLIENTS; i >= 1; i--) begin
                cand = int'(rr_ptr) + i;
                if (cand >= N_CLIENTS) cand = cand - N_CLIENTS;
                if (i_req[IDX_W'(cand)]) begin
                    win_found = 1'b1;
                    win_idx   = IDX_W'(cand);
                end
            end
        end
        if (win_found) o_gnt[win_idx] = 1'b1;
    end

    // Storage drive, lock ownership and the read-tag pipeline all advance on
    // the transfer edge; tag stage 0 lines up with o_mem_addr.
    always_ff @(posedge clk or posedge sys_rst) begin
        if (sys_rst) begin
            rr_ptr      <= IDX_W'(N_CLIENTS - 1);
            lock_valid  <= 1'b0;
            lock_idx    <= '0;
            o_mem_we    <= 1'b0;
            o_mem_addr  <= '0;
            o_mem_wdata <= '0;
            o_rvalid    <= '0;
            o_rdata     <= '0;
            tag_valid   <= '0;
            for (int i = 0; i < RD_LATENCY; i++) tag_idx[i] <= '0;
        end else begin
            o_mem_we   <= 1'b0;
            lock_valid <= win_found && i_lock[win_idx];
            lock_idx   <= win_idx;
            if (win_found) begin
                o_mem_we    <= i_we[win_idx];
                o_mem_addr  <= i_addr[win_idx*ADDR_W +: ADDR_W];
                o_mem_wdata <= i_wdata[win_idx*DATA_W +: DATA_W];
                rr_ptr      <= win_idx;
            end
            tag_valid[0] <= win_found && !i_we[win_idx];
            tag_idx[0]   <= win_idx;
            for (int i = 1; i < RD_LATENCY; i++) begin
                tag_valid[i] <= tag_valid[i-1];
                tag_idx[i]   <= tag_idx[i-1];
            end
            o_rvalid <= '0;
            if (tag_valid[RD_LATENCY-1]) begin
                o_rvalid[tag_idx[RD_LATENCY-1]] <= 1'b1;
                o_rdata                         <= i_mem_rdata;
            end
        end
    end

    assign o_busy = (|tag_valid) || lock_valid;

endmodule

// File: tb/tb_storage_arbiter.sv
// Self-checking bench: dut 0 is round-robin with RD_LATENCY=1, dut 1 is fixed
// priority with RD_LATENCY=3; each has its own storage model.
module tb_storage_arbiter;

    logic         clk;
    logic [1:0]   rst;
    logic [3:0]   req     [2];
    logic [3:0]   we      [2];
    logic [3:0]   lock    [2];
    logic [31:0]  addr    [2];
    logic [127:0] wdata   [2];
    logic [3:0]   gnt     [2];
    logic [3:0]   rvalid  [2];
    logic [31:0]  rdata   [2];
    logic         mem_we  [2];
    logic [7:0]   mem_addr[2];
    logic [31:0]  mem_wdata[2];
    logic [31:0]  mem_rdata[2];
    logic         busy    [2];

    logic [31:0]  mem     [2][256];
    logic [31:0]  rd_pipe [2][2];
    logic         pre_en;
    int           pre_d;
    logic [7:0]   pre_addr;
    logic [31:0]  pre_data;

    int total;
    int bad;

    typedef struct {
        int          due;
        int          client;
        logic [31:0] data;
    } ret_t;

    storage_arbiter #(.N_CLIENTS(4), .ADDR_W(8), .DATA_W(32), .RD_LATENCY(1), .PRIO_MODE(0)) dut_rr (
        .clk(clk), .sys_rst(rst[0]), .i_req(req[0]), .i_we(we[0]), .i_lock(lock[0]),
        .i_addr(addr[0]), .i_wdata(wdata[0]), .o_gnt(gnt[0]), .o_rvalid(rvalid[0]),
        .o_rdata(rdata[0]), .o_mem_we(mem_we[0]), .o_mem_addr(mem_addr[0]),
        .o_mem_wdata(mem_wdata[0]), .i_mem_rdata(mem_rdata[0]), .o_busy(busy[0])
    );

    storage_arbiter #(.N_CLIENTS(4), .ADDR_W(8), .DATA_W(32), .RD_LATENCY(3), .PRIO_MODE(1)) dut_fp (
        .clk(clk), .sys_rst(rst[1]), .i_req(req[1]), .i_we(we[1]), .i_lock(lock[1]),
        .i_addr(addr[1]), .i_wdata(wdata[1]), .o_gnt(gnt[1]), .o_rvalid(rvalid[1]),
        .o_rdata(rdata[1]), .o_mem_we(mem_we[1]), .o_mem_addr(mem_addr[1]),
        .o_mem_wdata(mem_wdata[1]), .i_mem_rdata(mem_rdata[1]), .o_busy(busy[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Storage models: data for an address presented in cycle c is visible to
    // the arbiter during cycle c+RD_LATENCY-1.
    always @(posedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (mem_we[d]) mem[d][mem_addr[d]] <= mem_wdata[d];
            rd_pipe[d][0] <= mem[d][mem_addr[d]];
            rd_pipe[d][1] <= rd_pipe[d][0];
        end
        if (pre_en) mem[pre_d][pre_addr] <= pre_data;
    end

    assign mem_rdata[0] = mem[0][mem_addr[0]];
    assign mem_rdata[1] = rd_pipe[1][1];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int d);
        req[d]   = '0;
        we[d]    = '0;
        lock[d]  = '0;
        addr[d]  = '0;
        wdata[d] = '0;
    endtask

    task automatic set_client(input int d, input int k, input logic r, input logic w,
                              input logic l, input logic [7:0] a, input logic [31:0] v);
        req[d][k]             = r;
        we[d][k]              = w;
        lock[d][k]            = l;
        addr[d][k*8 +: 8]     = a;
        wdata[d][k*32 +: 32]  = v;
    endtask

    task automatic do_reset(input int d);
        idle(d);
        rst[d] = 1'b1;
        step();
        rst[d] = 1'b0;
    endtask

    task automatic preload(input int d, input logic [7:0] a, input logic [31:0] v);
        pre_en   = 1'b1;
        pre_d    = d;
        pre_addr = a;
        pre_data = v;
        step();
        pre_en   = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            total++;
            if ({gnt[d], rvalid[d], rdata[d], busy[d], mem_we[d], mem_addr[d], mem_wdata[d]} !== '0) begin
                bad++;
                $display("FAIL reset_state dut%0d: gnt=%b rvalid=%b rdata=%h busy=%b we=%b addr=%h wdata=%h, want all zero",
                         d, gnt[d], rvalid[d], rdata[d], busy[d], mem_we[d], mem_addr[d], mem_wdata[d]);
            end
        end
        step();
    endtask

    task automatic test_single_read();
        preload(0, 8'h10, 32'h0000_00AB);
        set_client(0, 2, 1'b1, 1'b0, 1'b0, 8'h10, 32'h0);
        @(negedge clk);
        total++;
        if (gnt[0] !== 4'b0100) begin
            bad++; $display("FAIL single_gnt: got %b want 0100", gnt[0]);
        end
        step();
        idle(0);
        @(negedge clk);
        total++;
        if ({mem_we[0], mem_addr[0], busy[0], rvalid[0]} !== {1'b0, 8'h10, 1'b1, 4'b0000}) begin
            bad++; $display("FAIL single_addr: we=%b addr=%h busy=%b rvalid=%b want 0 10 1 0000",
                            mem_we[0], mem_addr[0], busy[0], rvalid[0]);
        end
        step();
        @(negedge clk);
        total++;
        if (rvalid[0] !== 4'b0100 || rdata[0] !== 32'hAB) begin
            bad++; $display("FAIL single_return: rvalid=%b rdata=%h want 0100 000000ab", rvalid[0], rdata[0]);
        end
        step();
        @(negedge clk);
        total++;
        if (rvalid[0] !== 4'b0000) begin
            bad++; $display("FAIL single_pulse_width: rvalid=%b want 0000", rvalid[0]);
        end
        step();
    endtask

    task automatic test_round_robin();
        rst = 2'b11;
        step();
        rst = 2'b00;
        for (int d = 0; d < 2; d++)
            for (int k = 0; k < 4; k++)
                set_client(d, k, 1'b1, 1'b1, 1'b0, 8'(8'h60 + k), 32'(k));
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            total++;
            if (gnt[0] !== 4'(1 << (i % 4))) begin
                bad++; $display("FAIL rr_grant cycle %0d: got %b want %b", i, gnt[0], 4'(1 << (i % 4)));
            end
            total++;
            if (gnt[1] !== 4'b0001) begin
                bad++; $display("FAIL fixed_grant cycle %0d: got %b want 0001", i, gnt[1]);
            end
            step();
        end
        idle(0);
        idle(1);
        step();
    endtask

    task automatic test_lock_burst();
        do_reset(0);
        set_client(0, 0, 1'b1, 1'b1, 1'b0, 8'h50, 32'h5);
        @(negedge clk);
        total++;
        if (gnt[0] !== 4'b0001) begin
            bad++; $display("FAIL lock_pre_grant: got %b want 0001", gnt[0]);
        end
        step();
        set_client(0, 0, 1'b1, 1'b1, 1'b0, 8'h51, 32'h6);
        for (int i = 0; i < 3; i++) begin
            set_client(0, 1, 1'b1, 1'b1, 1'b1, 8'(8'h30 + i), 32'(32'h100 + i));
            @(negedge clk);
            total++;
            if (gnt[0] !== 4'b0010) begin
                bad++; $display("FAIL lock_burst_grant beat %0d: got %b want 0010", i, gnt[0]);
            end
            if (i > 0) begin
                total++;
                if ({busy[0], mem_we[0], mem_addr[0]} !== {1'b1, 1'b1, 8'(8'h30 + i - 1)}) begin
                    bad++; $display("FAIL lock_burst_mem beat %0d: busy=%b we=%b addr=%h want 1 1 %h",
                                    i, busy[0], mem_we[0], mem_addr[0], 8'(8'h30 + i - 1));
                end
            end
            step();
        end
        set_client(0, 1, 1'b0, 1'b0, 1'b0, 8'h0, 32'h0);
        @(negedge clk);
        total++;
        if (gnt[0] !== 4'b0001) begin
            bad++; $display("FAIL lock_release_grant: got %b want 0001", gnt[0]);
        end
        step();
        idle(0);
        @(negedge clk);
        total++;
        if ({busy[0], mem_addr[0], mem_wdata[0]} !== {1'b0, 8'h51, 32'h6}) begin
            bad++; $display("FAIL lock_after: busy=%b addr=%h wdata=%h want 0 51 00000006",
                            busy[0], mem_addr[0], mem_wdata[0]);
        end
        step();
    endtask

    task automatic test_pipelined_reads();
        logic [3:0]  exp_rv [8];
        logic [31:0] exp_rd [8];
        do_reset(1);
        preload(1, 8'h40, 32'h1111_1111);
        preload(1, 8'h41, 32'h2222_2222);
        preload(1, 8'h42, 32'h3333_3333);
        for (int c = 0; c < 8; c++) begin
            exp_rv[c] = '0;
            exp_rd[c] = '0;
        end
        exp_rv[4] = 4'b0001; exp_rd[4] = 32'h1111_1111;
        exp_rv[5] = 4'b1000; exp_rd[5] = 32'h2222_2222;
        exp_rv[6] = 4'b0010; exp_rd[6] = 32'h3333_3333;
        for (int c = 0; c < 8; c++) begin
            idle(1);
            if (c == 0) set_client(1, 0, 1'b1, 1'b0, 1'b0, 8'h40, 32'h0);
            if (c == 1) set_client(1, 3, 1'b1, 1'b0, 1'b0, 8'h41, 32'h0);
            if (c == 2) set_client(1, 1, 1'b1, 1'b0, 1'b0, 8'h42, 32'h0);
            @(negedge clk);
            total++;
            if (rvalid[1] !== exp_rv[c] || (exp_rv[c] != 0 && rdata[1] !== exp_rd[c])) begin
                bad++; $display("FAIL pipe_return cycle %0d: rvalid=%b rdata=%h want %b %h",
                                c, rvalid[1], rdata[1], exp_rv[c], exp_rd[c]);
            end
            step();
        end
    endtask

    task automatic test_reset_mid_flight();
        do_reset(0);
        set_client(0, 3, 1'b1, 1'b0, 1'b1, 8'h10, 32'h0);
        @(negedge clk);
        total++;
        if (gnt[0] !== 4'b1000) begin
            bad++; $display("FAIL midrst_grant: got %b want 1000", gnt[0]);
        end
        step();
        rst[0] = 1'b1;
        @(negedge clk);
        step();
        rst[0] = 1'b0;
        for (int k = 0; k < 4; k++) set_client(0, k, 1'b1, 1'b1, k == 3, 8'h70, 32'h0);
        @(negedge clk);
        total++;
        if ({gnt[0], rvalid[0], busy[0]} !== {4'b0001, 4'b0000, 1'b0}) begin
            bad++; $display("FAIL midrst_after: gnt=%b rvalid=%b busy=%b want 0001 0000 0",
                            gnt[0], rvalid[0], busy[0]);
        end
        step();
        idle(0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            total++;
            if (rvalid[0] !== 4'b0000) begin
                bad++; $display("FAIL midrst_no_return cycle %0d: rvalid=%b want 0000", i, rvalid[0]);
            end
            step();
        end
    endtask

    task automatic test_write_read();
        do_reset(0);
        set_client(0, 0, 1'b1, 1'b1, 1'b0, 8'h20, 32'hDEAD_BEEF);
        @(negedge clk);
        total++;
        if (gnt[0] !== 4'b0001) begin
            bad++; $display("FAIL wr_grant: got %b want 0001", gnt[0]);
        end
        step();
        idle(0);
        set_client(0, 1, 1'b1, 1'b0, 1'b0, 8'h20, 32'h0);
        @(negedge clk);
        total++;
        if (gnt[0] !== 4'b0010 || rvalid[0] !== 4'b0000) begin
            bad++; $display("FAIL rd_grant: gnt=%b rvalid=%b want 0010 0000", gnt[0], rvalid[0]);
        end
        step();
        idle(0);
        @(negedge clk);
        total++;
        if ({rvalid[0], mem_we[0], mem_addr[0]} !== {4'b0000, 1'b0, 8'h20}) begin
            bad++; $display("FAIL rd_issue: rvalid=%b we=%b addr=%h want 0000 0 20", rvalid[0], mem_we[0], mem_addr[0]);
        end
        step();
        @(negedge clk);
        total++;
        if (rvalid[0] !== 4'b0010 || rdata[0] !== 32'hDEAD_BEEF) begin
            bad++; $display("FAIL rd_return: rvalid=%b rdata=%h want 0010 deadbeef", rvalid[0], rdata[0]);
        end
        step();
    endtask

    // Randomised traffic against a transaction-level model: clients hold a
    // request until served, locked owners may extend bursts, reads return
    // in issue order RD_LATENCY+1 cycles after grant.
    task automatic test_random(input int d, input int rl, input int prio, input int ncyc);
        logic [31:0] ref_mem [16];
        logic        p_req [4];
        logic        p_we  [4];
        logic        p_lock[4];
        logic [7:0]  p_addr[4];
        logic [31:0] p_data[4];
        ret_t        q[$];
        int          ptr;
        int          owner;
        int          win;
        int          c;
        logic [3:0]  exp_gnt;
        logic [3:0]  exp_rv;
        logic [31:0] exp_rd;
        logic        exp_busy;
        logic        allow_new;
        ret_t        r;

        do_reset(d);
        for (int a = 0; a < 16; a++) begin
            ref_mem[a] = $urandom;
            preload(d, 8'(a), ref_mem[a]);
        end
        for (int k = 0; k < 4; k++) begin
            p_req[k] = 1'b0; p_we[k] = 1'b0; p_lock[k] = 1'b0; p_addr[k] = '0; p_data[k] = '0;
        end
        ptr   = 3;
        owner = -1;
        for (int cyc = 0; cyc < ncyc + 12; cyc++) begin
            allow_new = (cyc < ncyc);
            for (int k = 0; k < 4; k++) begin
                if (!p_req[k] && allow_new && $urandom_range(0, 2) == 0) begin
                    p_req[k]  = 1'b1;
                    p_we[k]   = 1'($urandom_range(0, 1));
                    p_lock[k] = ($urandom_range(0, 3) == 0);
                    p_addr[k] = 8'($urandom_range(0, 15));
                    p_data[k] = $urandom;
                end
                set_client(d, k, p_req[k], p_we[k],
                           p_req[k] ? p_lock[k] : 1'($urandom_range(0, 1)), p_addr[k], p_data[k]);
            end

            win = -1;
            if (owner >= 0 && p_req[owner] && p_lock[owner]) win = owner;
            else if (prio == 1) begin
                for (int k = 3; k >= 0; k--) if (p_req[k]) win = k;
            end else begin
                for (int j = 1; j <= 4; j++) begin
                    c = (ptr + j) % 4;
                    if (win < 0 && p_req[c]) win = c;
                end
            end
            exp_gnt = (win >= 0) ? 4'(1 << win) : 4'b0000;
            exp_rv  = '0;
            exp_rd  = '0;
            if (q.size() > 0 && q[0].due == cyc) begin
                r = q.pop_front();
                exp_rv = 4'(1 << r.client);
                exp_rd = r.data;
            end
            exp_busy = (q.size() != 0) || (owner >= 0);

            @(negedge clk);
            total++;
            if (gnt[d] !== exp_gnt) begin
                bad++; $display("FAIL rand_gnt dut%0d cycle %0d: got %b want %b", d, cyc, gnt[d], exp_gnt);
            end
            total++;
            if (rvalid[d] !== exp_rv || (exp_rv != 0 && rdata[d] !== exp_rd)) begin
                bad++; $display("FAIL rand_return dut%0d cycle %0d: rvalid=%b rdata=%h want %b %h",
                                d, cyc, rvalid[d], rdata[d], exp_rv, exp_rd);
            end
            total++;
            if (busy[d] !== exp_busy) begin
                bad++; $display("FAIL rand_busy dut%0d cycle %0d: got %b want %b", d, cyc, busy[d], exp_busy);
            end

            if (win >= 0) begin
                ptr = win;
                if (p_we[win]) ref_mem[p_addr[win][3:0]] = p_data[win];
                else q.push_back('{cyc + rl + 1, win, ref_mem[p_addr[win][3:0]]});
                owner = p_lock[win] ? win : -1;
                p_req[win] = 1'b0;
                if (p_lock[win] && allow_new && $urandom_range(0, 3) != 0) begin
                    p_req[win]  = 1'b1;
                    p_we[win]   = 1'($urandom_range(0, 1));
                    p_lock[win] = ($urandom_range(0, 3) != 0);
                    p_addr[win] = 8'($urandom_range(0, 15));
                    p_data[win] = $urandom;
                end
            end else begin
                owner = -1;
            end
            step();
        end
        total++;
        if (q.size() != 0) begin
            bad++; $display("FAIL rand_drain dut%0d: %0d reads never returned, want 0", d, q.size());
        end
        idle(d);
    endtask

    initial begin
        total  = 0;
        bad    = 0;
        pre_en = 1'b0;
        pre_d  = 0;
        pre_addr = '0;
        pre_data = '0;
        idle(0);
        idle(1);
        rst = 2'b11;
        repeat (2) @(posedge clk);
        #1;
        rst = 2'b00;
        test_reset();
        test_single_read();
        test_round_robin();
        test_lock_burst();
        test_pipelined_reads();
        test_reset_mid_flight();
        test_write_read();
        test_random(0, 1, 0, 400);
        test_random(1, 3, 1, 400);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
